alu_sequencer: RTL and testbench
================================

# alu_sequencer

Instruction sequencer directly upstream of the 16-bit ALU datapath. Accepts 16-bit instruction words over a valid/ready handshake, decodes them, fetches operands from memory when needed, and drives the datapath's register-select, write-enable, ALU op-code and `ack` strobes for exactly one cycle per instruction. It also tracks retired instructions and flags illegal encodings.

## Interface
- No parameters; all widths are fixed.
- `clk` in 1: rising-edge clock shared with the datapath.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction word present.
- `instr` in 16: instruction word.
- `instr_ready` out 1: sequencer can accept an instruction.
- `mem_addr` out 8: operand address for LOAD.
- `mem_rd` out 1: memory read request.
- `mem_valid` in 1: memory data valid on the datapath's X/Y memory inputs.
- `ack` out 1: datapath commit strobe.
- `op_code_alu` out 4: ALU operation.
- `aregread`, `cregread` out 1 each: X = A (else B); Y = C.
- `aregwrite`, `bregwrite`, `cregwrite` out 1 each: register write enables.
- `aoutregread`, `boutregread`, `coutregread` out 1 each: output-register source select.
- `outregwrite` out 2: ALU result destination (01 Aout, 10 Bout, 11 Cout).
- `busy` out 1: an instruction is in flight (state ≠ IDLE/HALTED).
- `halted` out 1: HALT executed.
- `err` out 1: sticky illegal-instruction flag.
- `retired` out 16: count of committed instructions, wraps.

## Operation
- Encoding uses `instr[15:14]` as the class field.
  - 00 LOAD: dst `[13:12]` (01 A, 10 B, 11 C), addr `[7:0]`. A and B take memory X data; C takes memory Y data.
  - 01 EXEC: op `[13:10]`, xsel `[9]` (1 A, 0 B), ysel `[8:7]` (00 C, 01 Aout, 10 Bout, 11 Cout), dst `[6:5]` → `outregwrite`.
  - 10 MOVE: dst `[13:12]` (01 A, 10 B, 11 C), src `[11:10]` (01 Aout, 10 Bout, 11 Cout).
  - 11: `[13]`=1 is HALT; otherwise NOP.
- Illegal encodings:
  - LOAD with dst 00.
  - EXEC with dst 00.
  - MOVE with dst 00 or src 00.
  - MOVE A←Cout (the datapath has no such path).
- FSM states: IDLE, DECODE, MEM_WAIT, COMMIT, HALTED.
  - IDLE: `instr_ready`=1. On `instr_valid`, capture `instr` and go to DECODE.
  - DECODE, by class:
    - Illegal: set `err`, return to IDLE.
    - NOP: increment `retired`, return to IDLE.
    - HALT: increment `retired`, go to HALTED.
    - LOAD: go to MEM_WAIT.
    - EXEC/MOVE: go to COMMIT.
  - MEM_WAIT: `mem_rd`=1 and `mem_addr`=addr. Stay until `mem_valid`=1, then go to COMMIT.
  - COMMIT: `ack`=1 and decoded controls asserted for one cycle. For LOAD, `mem_rd` is also held. Increment `retired`, return to IDLE.
  - HALTED: `instr_ready`=0. Left only by reset.
- Control outputs outside COMMIT:
  - All datapath controls, `ack` and `op_code_alu` are 0.
  - `mem_rd`/`mem_addr` are 0 outside MEM_WAIT/COMMIT.
- Control values in COMMIT:
  - LOAD: the matching `*regwrite`=1; all `*outregread`=0.
  - EXEC: `aregread`=xsel. `cregread`, `aoutregread`, `boutregread`, `coutregread` are one-hot per ysel. `op_code_alu`=op, `outregwrite`=dst, all `*regwrite`=0.
  - MOVE: the matching `*regwrite`=1 plus the matching `*outregread`=1; `outregwrite`=00.
- At most one `*regwrite` and at most one Y-source select are high in any cycle.
- `retired` is a 16-bit counter that wraps from 0xFFFF to 0x0000. Illegal instructions are not counted.
- Memory contract: memory holds X/Y data stable from `mem_valid` until `mem_rd` drops.

## Timing
- Reset: on the first edge with `reset`=1:
  - state → IDLE.
  - `err`, `halted`, `retired` → 0.
  - All controls, `ack`, `mem_rd`, `mem_addr`, `busy` → 0.
  - `instr_ready` = 1 from the next cycle.
  - Reset in any state, including MEM_WAIT or COMMIT, aborts the instruction with no `ack` and no count.
- Handshake: transfer occurs on the edge where `instr_valid` && `instr_ready`. `instr` is ignored otherwise. `instr_ready` drops the cycle after acceptance.
- Latency from the accept edge (cycle 0):
  - EXEC/MOVE: DECODE in cycle 1, COMMIT (`ack`) in cycle 2; the datapath updates at the end of cycle 2. `instr_ready` returns in cycle 3.
  - LOAD: MEM_WAIT from cycle 2. COMMIT is one cycle after the edge sampling `mem_valid`=1. With zero-wait memory, `ack` falls in cycle 3.
  - NOP/illegal: back in IDLE at cycle 2.
- Throughput: one EXEC per 3 cycles.
- `ack` is never high for two consecutive cycles.

## Test plan
- Reset, then EXEC 0x4000|op=3,xsel=1,ysel=00,dst=01 → cycle 2 shows `ack`=1, `op_code_alu`=3, `aregread`=1, `cregread`=1, `outregwrite`=01; `retired`=1; `instr_ready` back in cycle 3.
- LOAD C addr 0x5A with `mem_valid` delayed 4 cycles → `mem_rd`=1 and `mem_addr`=0x5A held throughout; `ack` with `cregwrite`=1 one cycle after `mem_valid`; no `ack` earlier.
- MOVE B←Cout (0x8C00|0x2000) → COMMIT shows `bregwrite`=1, `coutregread`=1, all other controls 0.
- Illegal MOVE A←Cout (0x9C00), then a valid EXEC → `err`=1 sticky, no `ack` for the MOVE, EXEC proceeds normally, `retired` counts only the EXEC.
- HALT (0xE000) then `instr_valid` held high → `halted`=1, `instr_ready`=0 indefinitely; reset restores `instr_ready`=1, `halted`=0.
- `reset` asserted during MEM_WAIT; and separately 65536 NOPs → no `ack` and controls 0 after reset; `retired` wraps to 0x0000.

Source files
------------

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 16-bit ALU datapath. It decodes LOAD/EXEC/MOVE/SYS
// words and drives one-cycle commit controls. It also counts retired instructions and flags illegal ones.
`timescale 1ns/1ps
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  input  logic        mem_valid,
  output logic        ack,
  output logic [3:0]  op_code_alu,
  output logic        aregread,
  output logic        cregread,
  output logic        aregwrite,
  output logic        bregwrite,
  output logic        cregwrite,
  output logic        aoutregread,
  output logic        boutregread,
  output logic        coutregread,
  output logic [1:0]  outregwrite,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  localparam int unsigned IW  = 16;
  localparam int unsigned AW  = 8;
  localparam int unsigned CNW = 16;

  localparam logic [1:0] CLS_LOAD = 2'b00;
  localparam logic [1:0] CLS_EXEC = 2'b01;
  localparam logic [1:0] CLS_MOVE = 2'b10;
  localparam logic [1:0] CLS_SYS  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_MEM_WAIT,
    S_COMMIT,
    S_HALTED
  } state_e;

  typedef struct packed {
    logic       aregread;
    logic       cregread;
    logic       aregwrite;
    logic       bregwrite;
    logic       cregwrite;
    logic       aoutregread;
    logic       boutregread;
    logic       coutregread;
    logic [1:0] outregwrite;
    logic [3:0] op;
  } ctl_t;

  state_e          state_q;
  logic [IW-1:0]   instr_q;
  ctl_t            ctl_q;
  ctl_t            ctl_d;
  logic            dec_illegal;
  logic            ack_q;
  logic            mem_rd_q;
  logic [AW-1:0]   mem_addr_q;
  logic            ready_q;
  logic            busy_q;
  logic            halted_q;
  logic            err_q;
  logic [CNW-1:0]  retired_q;

  logic [1:0] cls;
  logic [1:0] dst;
  logic [1:0] src;
  logic [1:0] ysel;
  logic [1:0] ex_dst;

  assign cls    = instr_q[15:14];
  assign dst    = instr_q[13:12];
  assign src    = instr_q[11:10];
  assign ysel   = instr_q[8:7];
  assign ex_dst = instr_q[6:5];

  // Decode the captured word into the control set presented during COMMIT.
  always_comb begin
    ctl_d       = '0;
    dec_illegal = 1'b0;
    case (cls)
      CLS_LOAD: begin
        dec_illegal     = (dst == 2'b00);
        ctl_d.aregwrite = (dst == 2'b01);
        ctl_d.bregwrite = (dst == 2'b10);
        ctl_d.cregwrite = (dst == 2'b11);
      end
      CLS_EXEC: begin
        dec_illegal       = (ex_dst == 2'b00);
        ctl_d.aregread    = instr_q[9];
        ctl_d.cregread    = (ysel == 2'b00);
        ctl_d.aoutregread = (ysel == 2'b01);
        ctl_d.boutregread = (ysel == 2'b10);
        ctl_d.coutregread = (ysel == 2'b11);
        ctl_d.outregwrite = ex_dst;
        ctl_d.op          = instr_q[13:10];
      end
      CLS_MOVE: begin
        // The datapath has no Cout -> A path.
        dec_illegal       = (dst == 2'b00) || (src == 2'b00) ||
                            ((dst == 2'b01) && (src == 2'b11));
        ctl_d.aregwrite   = (dst == 2'b01);
        ctl_d.bregwrite   = (dst == 2'b10);
        ctl_d.cregwrite   = (dst == 2'b11);
        ctl_d.aoutregread = (src == 2'b01);
        ctl_d.boutregread = (src == 2'b10);
        ctl_d.coutregread = (src == 2'b11);
      end
      default: begin
      end
    endcase
  end

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      ctl_q      <= '0;
      ack_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      retired_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= S_DECODE;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (cls == CLS_SYS) begin
            retired_q <= retired_q + CNW'(1);
            busy_q    <= 1'b0;
            if (instr_q[13]) begin
              state_q  <= S_HALTED;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end
          end else if (cls == CLS_LOAD) begin
            state_q    <= S_MEM_WAIT;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= instr_q[7:0];
          end else begin
            state_q   <= S_COMMIT;
            ctl_q     <= ctl_d;
            ack_q     <= 1'b1;
            retired_q <= retired_q + CNW'(1);
          end
        end
        S_MEM_WAIT: begin
          if (mem_valid) begin
            state_q   <= S_COMMIT;
            ctl_q     <= ctl_d;
            ack_q     <= 1'b1;
            retired_q <= retired_q + CNW'(1);
          end
        end
        S_COMMIT: begin
          state_q    <= S_IDLE;
          ctl_q      <= '0;
          ack_q      <= 1'b0;
          mem_rd_q   <= 1'b0;
          mem_addr_q <= '0;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
        end
        S_HALTED: begin
        end
        default: begin
          state_q    <= S_IDLE;
          ctl_q      <= '0;
          ack_q      <= 1'b0;
          mem_rd_q   <= 1'b0;
          mem_addr_q <= '0;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign ack         = ack_q;
  assign op_code_alu = ctl_q.op;
  assign aregread    = ctl_q.aregread;
  assign cregread    = ctl_q.cregread;
  assign aregwrite   = ctl_q.aregwrite;
  assign bregwrite   = ctl_q.bregwrite;
  assign cregwrite   = ctl_q.cregwrite;
  assign aoutregread = ctl_q.aoutregread;
  assign boutregread = ctl_q.boutregread;
  assign coutregread = ctl_q.coutregread;
  assign outregwrite = ctl_q.outregwrite;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: each scenario task drives a short stimulus
// sequence and compares against hand-computed control vectors.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_valid;
  logic        ack;
  logic [3:0]  op_code_alu;
  logic        aregread;
  logic        cregread;
  logic        aregwrite;
  logic        bregwrite;
  logic        cregwrite;
  logic        aoutregread;
  logic        boutregread;
  logic        coutregread;
  logic [1:0]  outregwrite;
  logic        busy;
  logic        halted;
  logic        err;
  logic [15:0] retired;

  int n_cmp;
  int n_bad;

  // {ack, aregread, cregread, aregwrite, bregwrite, cregwrite,
  //  aoutregread, boutregread, coutregread, outregwrite[1:0], op_code_alu[3:0]}
  logic [14:0] ctl;
  assign ctl = {ack, aregread, cregread, aregwrite, bregwrite, cregwrite,
                aoutregread, boutregread, coutregread, outregwrite, op_code_alu};

  localparam logic [14:0] CTL_IDLE   = 15'b000_000_000_00_0000;
  localparam logic [14:0] CTL_EXEC1  = 15'b111_000_000_01_0011;
  localparam logic [14:0] CTL_LOADC  = 15'b100_001_000_00_0000;
  localparam logic [14:0] CTL_MOVEBC = 15'b100_010_001_00_0000;
  localparam logic [14:0] CTL_EXEC2  = 15'b100_000_010_11_0101;

  localparam logic [15:0] I_EXEC1  = 16'h4E20; // op 3, xsel A, ysel C, dst Aout
  localparam logic [15:0] I_LOADC  = 16'h305A; // LOAD C from 0x5A
  localparam logic [15:0] I_MOVEBC = 16'hAC00; // MOVE B <- Cout
  localparam logic [15:0] I_BADMV  = 16'h9C00; // MOVE A <- Cout (illegal)
  localparam logic [15:0] I_EXEC2  = 16'h5560; // op 5, xsel B, ysel Bout, dst Cout
  localparam logic [15:0] I_NOP    = 16'hC000;
  localparam logic [15:0] I_HALT   = 16'hE000;
  localparam logic [15:0] I_LOADA  = 16'h1011; // LOAD A from 0x11

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_valid   (mem_valid),
    .ack         (ack),
    .op_code_alu (op_code_alu),
    .aregread    (aregread),
    .cregread    (cregread),
    .aregwrite   (aregwrite),
    .bregwrite   (bregwrite),
    .cregwrite   (cregwrite),
    .aoutregread (aoutregread),
    .boutregread (boutregread),
    .coutregread (coutregread),
    .outregwrite (outregwrite),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr = '0; mem_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if (instr_ready !== 1'b1 || busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_status: ready=%b busy=%b halted=%b err=%b, required 1 0 0 0",
               instr_ready, busy, halted, err);
    end
    n_cmp++;
    if (ctl !== CTL_IDLE || mem_rd !== 1'b0 || mem_addr !== 8'h00 || retired !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_outputs: ctl=%b mem_rd=%b addr=%h retired=%h, required all zero",
               ctl, mem_rd, mem_addr, retired);
    end
  endtask

  task automatic test_exec();
    instr_valid = 1'b1; instr = I_EXEC1;
    tick();                                   // accept edge -> cycle 1
    instr_valid = 1'b0; instr = 16'hFFFF;
    n_cmp++;
    if (ctl !== CTL_IDLE || instr_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL exec_cycle1: ctl=%b ready=%b busy=%b, required ctl=%b ready=0 busy=1",
               ctl, instr_ready, busy, CTL_IDLE);
    end
    tick();                                   // cycle 2: commit
    n_cmp++;
    if (ctl !== CTL_EXEC1 || retired !== 16'd1 || instr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL exec_commit: ctl=%b retired=%0d ready=%b, required ctl=%b retired=1 ready=0",
               ctl, retired, instr_ready, CTL_EXEC1);
    end
    tick();                                   // cycle 3
    n_cmp++;
    if (ctl !== CTL_IDLE || instr_ready !== 1'b1 || busy !== 1'b0 || retired !== 16'd1) begin
      n_bad++;
      $display("FAIL exec_done: ctl=%b ready=%b busy=%b retired=%0d, required ctl=0 ready=1 busy=0 retired=1",
               ctl, instr_ready, busy, retired);
    end
  endtask

  task automatic test_load();
    instr_valid = 1'b1; instr = I_LOADC;
    tick();
    instr_valid = 1'b0;
    n_cmp++;
    if (mem_rd !== 1'b0 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL load_decode: mem_rd=%b ack=%b, required 0 0", mem_rd, ack);
    end
    tick();                                   // cycle 2: MEM_WAIT
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (mem_rd !== 1'b1 || mem_addr !== 8'h5A || ctl !== CTL_IDLE) begin
        n_bad++;
        $display("FAIL load_wait[%0d]: mem_rd=%b addr=%h ctl=%b, required 1 5a %b",
                 i, mem_rd, mem_addr, ctl, CTL_IDLE);
      end
      if (i == 4) mem_valid = 1'b1;
      tick();
    end
    mem_valid = 1'b0;
    n_cmp++;
    if (ctl !== CTL_LOADC || mem_rd !== 1'b1 || mem_addr !== 8'h5A || retired !== 16'd2) begin
      n_bad++;
      $display("FAIL load_commit: ctl=%b mem_rd=%b addr=%h retired=%0d, required ctl=%b 1 5a 2",
               ctl, mem_rd, mem_addr, retired, CTL_LOADC);
    end
    tick();
    n_cmp++;
    if (ctl !== CTL_IDLE || mem_rd !== 1'b0 || mem_addr !== 8'h00 || instr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL load_done: ctl=%b mem_rd=%b addr=%h ready=%b, required 0 0 00 1",
               ctl, mem_rd, mem_addr, instr_ready);
    end
  endtask

  task automatic test_move();
    instr_valid = 1'b1; instr = I_MOVEBC;
    tick();
    instr_valid = 1'b0;
    tick();
    n_cmp++;
    if (ctl !== CTL_MOVEBC || mem_rd !== 1'b0 || retired !== 16'd3) begin
      n_bad++;
      $display("FAIL move_commit: ctl=%b mem_rd=%b retired=%0d, required ctl=%b 0 3",
               ctl, mem_rd, retired, CTL_MOVEBC);
    end
    tick();
  endtask

  task automatic test_illegal();
    instr_valid = 1'b1; instr = I_BADMV;
    tick();
    instr_valid = 1'b0;
    n_cmp++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_decode: ack=%b err=%b, required 0 0", ack, err);
    end
    tick();                                   // cycle 2: back in IDLE
    n_cmp++;
    if (err !== 1'b1 || ctl !== CTL_IDLE || instr_ready !== 1'b1 || retired !== 16'd3) begin
      n_bad++;
      $display("FAIL illegal_flag: err=%b ctl=%b ready=%b retired=%0d, required 1 0 1 3",
               err, ctl, instr_ready, retired);
    end
    instr_valid = 1'b1; instr = I_EXEC2;
    tick();
    instr_valid = 1'b0;
    tick();
    n_cmp++;
    if (ctl !== CTL_EXEC2 || retired !== 16'd4 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_then_exec: ctl=%b retired=%0d err=%b, required ctl=%b 4 1",
               ctl, retired, err, CTL_EXEC2);
    end
    tick();
    n_cmp++;
    if (err !== 1'b1 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL err_sticky: err=%b ack=%b, required 1 0", err, ack);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_ack;
    logic [5:0] got_ack;
    exp_ack = 6'b010010;                      // cycle order 1..6, LSB first
    got_ack = '0;
    instr_valid = 1'b1; instr = I_EXEC1;
    for (int i = 0; i < 6; i++) begin
      tick();
      got_ack[i] = ack;
    end
    instr_valid = 1'b0;
    n_cmp++;
    if (got_ack !== exp_ack || retired !== 16'd6) begin
      n_bad++;
      $display("FAIL back_to_back: ack_seq=%b retired=%0d, required %b 6",
               got_ack, retired, exp_ack);
    end
    tick();
    tick();
  endtask

  task automatic test_halt();
    instr_valid = 1'b1; instr = I_HALT;
    tick();
    tick();
    n_cmp++;
    if (halted !== 1'b1 || instr_ready !== 1'b0 || busy !== 1'b0 || retired !== 16'd7) begin
      n_bad++;
      $display("FAIL halt_enter: halted=%b ready=%b busy=%b retired=%0d, required 1 0 0 7",
               halted, instr_ready, busy, retired);
    end
    instr = I_EXEC1;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (halted !== 1'b1 || instr_ready !== 1'b0 || ctl !== CTL_IDLE || retired !== 16'd7) begin
      n_bad++;
      $display("FAIL halt_hold: halted=%b ready=%b ctl=%b retired=%0d, required 1 0 0 7",
               halted, instr_ready, ctl, retired);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; instr_valid = 1'b0;
    n_cmp++;
    if (halted !== 1'b0 || instr_ready !== 1'b1 || err !== 1'b0 || retired !== 16'd0) begin
      n_bad++;
      $display("FAIL halt_reset: halted=%b ready=%b err=%b retired=%0d, required 0 1 0 0",
               halted, instr_ready, err, retired);
    end
  endtask

  task automatic test_reset_mem_wait();
    instr_valid = 1'b1; instr = I_LOADA;
    tick();
    instr_valid = 1'b0;
    tick();
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h11) begin
      n_bad++;
      $display("FAIL rst_mw_wait: mem_rd=%b addr=%h, required 1 11", mem_rd, mem_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_valid = 1'b1;
    n_cmp++;
    if (ctl !== CTL_IDLE || mem_rd !== 1'b0 || mem_addr !== 8'h00 || busy !== 1'b0 ||
        instr_ready !== 1'b1 || retired !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_mw_abort: ctl=%b mem_rd=%b addr=%h busy=%b ready=%b retired=%0d, required all idle",
               ctl, mem_rd, mem_addr, busy, instr_ready, retired);
    end
    tick();
    tick();
    mem_valid = 1'b0;
    n_cmp++;
    if (ack !== 1'b0 || aregwrite !== 1'b0 || retired !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_mw_late_valid: ack=%b aregwrite=%b retired=%0d, required 0 0 0",
               ack, aregwrite, retired);
    end
  endtask

  task automatic test_nop_wrap();
    // Ten real NOPs, then preload near the top to cross 0xFFFF cheaply.
    instr_valid = 1'b1; instr = I_NOP;
    for (int i = 0; i < 20; i++) tick();
    instr_valid = 1'b0;
    tick();
    n_cmp++;
    if (retired !== 16'd10 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL nop_count: retired=%0d ack=%b, required 10 0", retired, ack);
    end
    force dut.retired_q = 16'hFFFD;
    #1;
    release dut.retired_q;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (retired !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL nop_top: retired=%h, required ffff", retired);
    end
    tick();
    tick();
    instr_valid = 1'b0;
    n_cmp++;
    if (retired !== 16'h0000 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL nop_wrap: retired=%h ack=%b, required 0000 0", retired, ack);
    end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_exec();
    test_load();
    test_move();
    test_illegal();
    test_back_to_back();
    test_halt();
    test_reset_mem_wait();
    test_nop_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
